// File: rtl/rx_lane_frontend.sv
`default_nettype none
// ============================================================================
// Module   : rx_lane_frontend
// Purpose  : SerDes receive-lane front end in the recovered-clock domain.
//            Corrects polarity and bit order of the raw 32-bit word, qualifies
//            the stream with a synchronized SerDes-ready, and feeds the RX
//            async gearbox. Also hosts a loss-of-activity detector and a
//            self-synchronizing PRBS31 checker for link bring-up.
// Ports    : clk_in / clk_in_reset   recovered clock, async active-high reset
//            serdes_rx_ready         SerDes ready (asynchronous, synchronized)
//            serdes_data[31:0]       raw word, bit 0 received first
//            cfg_invert              invert all bits (quasi-static)
//            cfg_bit_reverse         reverse bit order (quasi-static)
//            prbs_check_en           enable PRBS31 checker
//            prbs_err_clear          one-cycle pulse, zeroes error counter
//            data_out[31:0]          corrected word to gearbox data_in
//            valid_out               qualifier to gearbox valid_in
//            signal_ok               activity detector status
//            prbs_locked             PRBS checker locked
//            prbs_err_count          saturating PRBS bit-error count
// Revision : 1.0 - initial release
// ============================================================================
module rx_lane_frontend #(
    parameter int STATIC_LIMIT    = 64,
    parameter int ACTIVE_LIMIT    = 16,
    parameter int PRBS_LOCK_WORDS = 8,
    parameter int ERR_CNT_W       = 16
) (
    input  logic                 clk_in,
    input  logic                 clk_in_reset,
    input  logic                 serdes_rx_ready,
    input  logic [31:0]          serdes_data,
    input  logic                 cfg_invert,
    input  logic                 cfg_bit_reverse,
    input  logic                 prbs_check_en,
    input  logic                 prbs_err_clear,
    output logic [31:0]          data_out,
    output logic                 valid_out,
    output logic                 signal_ok,
    output logic                 prbs_locked,
    output logic [ERR_CNT_W-1:0] prbs_err_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_ACT_MAX = (STATIC_LIMIT > ACTIVE_LIMIT) ? STATIC_LIMIT : ACTIVE_LIMIT;
    localparam int c_ACT_W   = $clog2(c_ACT_MAX + 1);
    localparam logic [c_ACT_W-1:0] c_ACT_LAST  = c_ACT_W'(ACTIVE_LIMIT - 1);
    localparam logic [c_ACT_W-1:0] c_STAT_LAST = c_ACT_W'(STATIC_LIMIT - 1);

    localparam int c_UNLOCK_WORDS = 4;
    localparam int c_RUN_MAX = (PRBS_LOCK_WORDS > c_UNLOCK_WORDS) ? PRBS_LOCK_WORDS : c_UNLOCK_WORDS;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
    localparam logic [c_RUN_W-1:0] c_LOCK_LAST   = c_RUN_W'(PRBS_LOCK_WORDS - 1);
    localparam logic [c_RUN_W-1:0] c_UNLOCK_LAST = c_RUN_W'(c_UNLOCK_WORDS - 1);

    // Popcount of a 32-bit mask needs 6 bits; the sum is widened by that much
    // so saturation can be decided without wrap-around.
    localparam int c_SUM_W = ERR_CNT_W + 6;
    localparam logic [c_SUM_W-1:0] c_ERR_MAX_EXT = {6'd0, {ERR_CNT_W{1'b1}}};

    typedef enum logic [0:0] {
        ACT_LOST = 1'b0,
        ACT_OK   = 1'b1
    } act_state_t;

    typedef enum logic [0:0] {
        PRBS_HUNT   = 1'b0,
        PRBS_LOCKED = 1'b1
    } prbs_state_t;

    // ------------------------------------------------------------------------
    // Ready synchronizer
    // ------------------------------------------------------------------------
    logic r_rdy_meta;
    logic r_rdy_s;

    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_rdy_meta <= 1'b0;
            r_rdy_s    <= 1'b0;
        end else begin
            r_rdy_meta <= serdes_rx_ready;
            r_rdy_s    <= r_rdy_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Correction and two-stage datapath
    // ------------------------------------------------------------------------
    logic [31:0] w_inv;
    logic [31:0] w_corr;

    always_comb begin
        w_inv  = serdes_data ^ {32{cfg_invert}};
        w_corr = w_inv;
        if (cfg_bit_reverse) begin
            for (int i = 0; i < 32; i++) begin
                w_corr[i] = w_inv[31-i];
            end
        end
    end

    logic [31:0] r_w1;
    logic        r_v1;
    logic [31:0] r_data_out;
    logic        r_valid_out;

    // Data moves every cycle; only the valid bit qualifies it, so a ready
    // drop lets already-captured words drain at normal latency.
    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_w1        <= 32'd0;
            r_v1        <= 1'b0;
            r_data_out  <= 32'd0;
            r_valid_out <= 1'b0;
        end else begin
            r_w1        <= w_corr;
            r_v1        <= r_rdy_s;
            r_data_out  <= r_w1;
            r_valid_out <= r_v1;
        end
    end

    // ------------------------------------------------------------------------
    // Activity detector (stage-1 words)
    // ------------------------------------------------------------------------
    act_state_t         r_act_state;
    act_state_t         w_act_state_nx;
    logic [c_ACT_W-1:0] r_act_cnt;
    logic [c_ACT_W-1:0] w_act_cnt_nx;
    logic               r_prev_vld;
    logic               w_prev_vld_nx;
    logic               r_prev_b31;
    logic               w_prev_b31_nx;
    logic               w_all_eq;
    logic               w_static;

    // A static word is a constant run continuing the previous word's level;
    // with no valid previous word every word counts as active.
    assign w_all_eq = (r_w1 == 32'h0000_0000) || (r_w1 == 32'hFFFF_FFFF);
    assign w_static = w_all_eq && r_prev_vld && (r_w1[31] == r_prev_b31);

    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_act_state <= ACT_LOST;
            r_act_cnt   <= '0;
            r_prev_vld  <= 1'b0;
            r_prev_b31  <= 1'b0;
        end else begin
            r_act_state <= w_act_state_nx;
            r_act_cnt   <= w_act_cnt_nx;
            r_prev_vld  <= w_prev_vld_nx;
            r_prev_b31  <= w_prev_b31_nx;
        end
    end

    always_comb begin
        w_act_state_nx = r_act_state;
        w_act_cnt_nx   = r_act_cnt;
        w_prev_vld_nx  = r_prev_vld;
        w_prev_b31_nx  = r_prev_b31;
        if (!r_rdy_s) begin
            w_act_state_nx = ACT_LOST;
            w_act_cnt_nx   = '0;
            w_prev_vld_nx  = 1'b0;
        end else if (r_v1) begin
            w_prev_vld_nx = 1'b1;
            w_prev_b31_nx = r_w1[31];
            case (r_act_state)
                ACT_LOST: begin
                    if (w_static) begin
                        w_act_cnt_nx = '0;
                    end else if (r_act_cnt == c_ACT_LAST) begin
                        w_act_state_nx = ACT_OK;
                        w_act_cnt_nx   = '0;
                    end else begin
                        w_act_cnt_nx = r_act_cnt + c_ACT_W'(1);
                    end
                end
                default: begin
                    if (!w_static) begin
                        w_act_cnt_nx = '0;
                    end else if (r_act_cnt == c_STAT_LAST) begin
                        w_act_state_nx = ACT_LOST;
                        w_act_cnt_nx   = '0;
                    end else begin
                        w_act_cnt_nx = r_act_cnt + c_ACT_W'(1);
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // PRBS31 checker, stage A: error mask (data_out words)
    // ------------------------------------------------------------------------
    // r_hist[j] is bit (n-31+j) relative to bit 0 of the current word, so the
    // extended vector below is indexed in received order. Prediction uses the
    // received bits themselves, which makes the checker self-synchronizing.
    logic [30:0] r_hist;
    logic        r_hist_ok;
    logic [31:0] r_mask;
    logic        r_mask_v;
    logic [34:0] w_ext;
    logic [31:0] w_pred;
    logic [31:0] w_mask;
    logic        w_prbs_to_hunt;

    assign w_ext = {r_data_out[3:0], r_hist};

    always_comb begin
        w_pred = '0;
        for (int i = 0; i < 32; i++) begin
            w_pred[i] = w_ext[i] ^ w_ext[i+3];
        end
        w_mask = w_pred ^ r_data_out;
    end

    // On a drop back to HUNT, the word captured in the same cycle only
    // reloads history; scoring restarts with the word after it.
    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_hist    <= '0;
            r_hist_ok <= 1'b0;
            r_mask    <= '0;
            r_mask_v  <= 1'b0;
        end else if (!prbs_check_en) begin
            r_hist_ok <= 1'b0;
            r_mask_v  <= 1'b0;
        end else if (r_valid_out) begin
            r_hist    <= r_data_out[31:1];
            r_mask    <= w_mask;
            r_mask_v  <= r_hist_ok && !w_prbs_to_hunt;
            r_hist_ok <= 1'b1;
        end else begin
            r_mask_v <= 1'b0;
            if (w_prbs_to_hunt) begin
                r_hist_ok <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // PRBS31 checker, stage B: lock FSM and error accumulation
    // ------------------------------------------------------------------------
    prbs_state_t          r_prbs_state;
    prbs_state_t          w_prbs_state_nx;
    logic [c_RUN_W-1:0]   r_run_cnt;
    logic [c_RUN_W-1:0]   w_run_cnt_nx;
    logic                 w_acc;
    logic                 w_mask_nz;
    logic [5:0]           w_pop;
    logic [c_SUM_W-1:0]   w_sum;
    logic [ERR_CNT_W-1:0] w_sum_sat;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_mask_nz = |r_mask;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < 32; i++) begin
            w_pop = w_pop + {5'd0, r_mask[i]};
        end
    end

    assign w_sum     = {6'd0, r_err_cnt} + {{ERR_CNT_W{1'b0}}, w_pop};
    assign w_sum_sat = (w_sum > c_ERR_MAX_EXT) ? {ERR_CNT_W{1'b1}} : w_sum[ERR_CNT_W-1:0];

    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_prbs_state <= PRBS_HUNT;
            r_run_cnt    <= '0;
        end else begin
            r_prbs_state <= w_prbs_state_nx;
            r_run_cnt    <= w_run_cnt_nx;
        end
    end

    // r_run_cnt counts clean words while hunting and errored words while
    // locked; any word of the other kind restarts it.
    always_comb begin
        w_prbs_state_nx = r_prbs_state;
        w_run_cnt_nx    = r_run_cnt;
        w_prbs_to_hunt  = 1'b0;
        w_acc           = 1'b0;
        if (!prbs_check_en) begin
            w_prbs_state_nx = PRBS_HUNT;
            w_run_cnt_nx    = '0;
        end else if (r_mask_v) begin
            case (r_prbs_state)
                PRBS_HUNT: begin
                    if (w_mask_nz) begin
                        w_run_cnt_nx = '0;
                    end else if (r_run_cnt == c_LOCK_LAST) begin
                        w_prbs_state_nx = PRBS_LOCKED;
                        w_run_cnt_nx    = '0;
                    end else begin
                        w_run_cnt_nx = r_run_cnt + c_RUN_W'(1);
                    end
                end
                default: begin
                    w_acc = 1'b1;
                    if (!w_mask_nz) begin
                        w_run_cnt_nx = '0;
                    end else if (r_run_cnt == c_UNLOCK_LAST) begin
                        w_prbs_state_nx = PRBS_HUNT;
                        w_run_cnt_nx    = '0;
                        w_prbs_to_hunt  = 1'b1;
                    end else begin
                        w_run_cnt_nx = r_run_cnt + c_RUN_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge clk_in_reset) begin
        if (clk_in_reset) begin
            r_err_cnt <= '0;
        end else if (prbs_err_clear) begin
            r_err_cnt <= '0;
        end else if (w_acc) begin
            r_err_cnt <= w_sum_sat;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign data_out       = r_data_out;
    assign valid_out      = r_valid_out;
    assign signal_ok      = (r_act_state == ACT_OK);
    assign prbs_locked    = (r_prbs_state == PRBS_LOCKED);
    assign prbs_err_count = r_err_cnt;

endmodule
`default_nettype wire
